// File: rtl/chip_rx.sv
// Chip-path receiver: buffers {sel, data} words and serialises each as an A5-headed byte frame.
// Define CHIP_RX_CHKSUM_EN to append an XOR checksum byte (5-byte frames).
module chip_rx #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned SKID  = 2
) (
    input  logic          i_clk_sys,
    input  logic          i_rst,
    input  logic [15:0]   i_chip_d,
    input  logic          i_chip_vld,
    input  logic [6:0]    i_chip_sel,
    output logic          o_chip_rdy,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_vld,
    input  logic          i_tx_done,
    output logic [7:0]    o_ovf_cnt,
    output logic [AW:0]   o_fifo_lvl
);

`ifdef CHIP_RX_CHKSUM_EN
    typedef enum logic [2:0] {StIdle, StHdr, StSel, StDhi, StDlo, StChk} state_e;
`else
    typedef enum logic [2:0] {StIdle, StHdr, StSel, StDhi, StDlo} state_e;
`endif

    logic [22:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_lvl;
    logic [7:0]    r_ovf;
    logic          r_rdy;
    state_e        r_state;
    logic [22:0]   r_word;
    logic [7:0]    r_tx_data;
    logic          r_tx_vld;

    logic          w_full;
    logic          w_empty;
    logic          w_last;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic [AW:0]   w_free;
    logic [22:0]   w_head;

    assign w_full  = (r_lvl == (AW+1)'(DEPTH));
    assign w_empty = (r_lvl == '0);
    assign w_free  = (AW+1)'(DEPTH) - r_lvl;
    assign w_head  = r_mem[r_rptr];
`ifdef CHIP_RX_CHKSUM_EN
    assign w_last  = (r_state == StChk);
`else
    assign w_last  = (r_state == StDlo);
`endif
    // Pop either from idle or on the final byte's done so frames run back-to-back.
    assign w_pop   = !w_empty && ((r_state == StIdle) || (w_last && i_tx_done));
    assign w_wr    = i_chip_vld && (!w_full || w_pop);
    assign w_drop  = i_chip_vld && w_full && !w_pop;

`ifdef CHIP_RX_CHKSUM_EN
    logic [7:0] w_chk;
    assign w_chk = {1'b0, r_word[22:16]} ^ r_word[15:8] ^ r_word[7:0];
`endif

    always_ff @(posedge i_clk_sys) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {i_chip_sel, i_chip_d};
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_lvl  <= '0;
            r_ovf  <= '0;
            r_rdy  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_lvl <= r_lvl + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_lvl <= r_lvl - 1'b1;
            end
            if (w_drop && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 1'b1;
            end
            r_rdy <= (w_free > (AW+1)'(SKID));
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_word    <= '0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
        end else begin
            r_tx_vld <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_word    <= w_head;
                        r_state   <= StHdr;
                        r_tx_vld  <= 1'b1;
                        r_tx_data <= 8'hA5;
                    end
                end
                StHdr: begin
                    if (i_tx_done) begin
                        r_state   <= StSel;
                        r_tx_vld  <= 1'b1;
                        r_tx_data <= {1'b0, r_word[22:16]};
                    end
                end
                StSel: begin
                    if (i_tx_done) begin
                        r_state   <= StDhi;
                        r_tx_vld  <= 1'b1;
                        r_tx_data <= r_word[15:8];
                    end
                end
                StDhi: begin
                    if (i_tx_done) begin
                        r_state   <= StDlo;
                        r_tx_vld  <= 1'b1;
                        r_tx_data <= r_word[7:0];
                    end
                end
`ifdef CHIP_RX_CHKSUM_EN
                StDlo: begin
                    if (i_tx_done) begin
                        r_state   <= StChk;
                        r_tx_vld  <= 1'b1;
                        r_tx_data <= w_chk;
                    end
                end
                StChk: begin
`else
                StDlo: begin
`endif
                    if (i_tx_done) begin
                        if (w_pop) begin
                            r_word    <= w_head;
                            r_state   <= StHdr;
                            r_tx_vld  <= 1'b1;
                            r_tx_data <= 8'hA5;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_chip_rdy = r_rdy;
    assign o_tx_data  = r_tx_data;
    assign o_tx_vld   = r_tx_vld;
    assign o_ovf_cnt  = r_ovf;
    assign o_fifo_lvl = r_lvl;

endmodule

// File: tb/tb_chip_rx.sv
// Directed bench for chip_rx: frame bytes, backpressure, overflow, back-to-back, wrap, reset.
// Honours CHIP_RX_CHKSUM_EN for the frame length.
module tb_chip_rx;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned SKID  = 2;
`ifdef CHIP_RX_CHKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [15:0]   i_chip_d = '0;
    logic          i_chip_vld = 1'b0;
    logic [6:0]    i_chip_sel = '0;
    logic          o_chip_rdy;
    logic [7:0]    o_tx_data;
    logic          o_tx_vld;
    logic          i_tx_done = 1'b0;
    logic [7:0]    o_ovf_cnt;
    logic [AW:0]   o_fifo_lvl;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    chip_rx #(.DEPTH(DEPTH), .AW(AW), .SKID(SKID)) dut (
        .i_clk_sys  (clk),
        .i_rst      (i_rst),
        .i_chip_d   (i_chip_d),
        .i_chip_vld (i_chip_vld),
        .i_chip_sel (i_chip_sel),
        .o_chip_rdy (o_chip_rdy),
        .o_tx_data  (o_tx_data),
        .o_tx_vld   (o_tx_vld),
        .i_tx_done  (i_tx_done),
        .o_ovf_cnt  (o_ovf_cnt),
        .o_fifo_lvl (o_fifo_lvl)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_rst      = 1'b1;
        i_chip_vld = 1'b0;
        i_tx_done  = 1'b0;
        cyc();
        cyc();
        i_rst = 1'b0;
        cyc();
    endtask

    task automatic put_word(input logic [6:0] s, input logic [15:0] d);
        i_chip_sel = s;
        i_chip_d   = d;
        i_chip_vld = 1'b1;
        cyc();
        i_chip_vld = 1'b0;
    endtask

    // exp_wait < 0 skips the latency comparison
    task automatic get_byte(input string tag, input logic [7:0] exp, input int exp_wait);
        int w = 0;
        while (!o_tx_vld && w < 200) begin
            cyc();
            w++;
        end
        check({tag, "_vld"}, {31'd0, o_tx_vld}, 32'd1);
        check(tag, {24'd0, o_tx_data}, {24'd0, exp});
        if (exp_wait >= 0) check({tag, "_gap"}, w, exp_wait);
    endtask

    task automatic send_done(input int d);
        for (int i = 0; i < d; i++) begin
            cyc();
            if (i == 0) check("vld_pulse", {31'd0, o_tx_vld}, 32'd0);
        end
        i_tx_done = 1'b1;
        cyc();
        i_tx_done = 1'b0;
    endtask

    function automatic logic [7:0] fbyte(input logic [6:0] s, input logic [15:0] d, input int k);
        case (k)
            0:       return 8'hA5;
            1:       return {1'b0, s};
            2:       return d[15:8];
            3:       return d[7:0];
            default: return {1'b0, s} ^ d[15:8] ^ d[7:0];
        endcase
    endfunction

    // dly < 0 picks a random tx_done delay per byte
    task automatic get_frame(input string tag, input logic [6:0] s, input logic [15:0] d,
                             input int k0, input int first_wait, input int dly);
        for (int k = k0; k < NB; k++) begin
            get_byte(tag, fbyte(s, d, k), (k == k0) ? first_wait : 0);
            send_done((dly < 0) ? int'($urandom_range(0, 4)) : dly);
        end
    endtask

    function automatic logic [6:0] wsel(input int i);
        return 7'((i * 3 + 1) & 127);
    endfunction

    function automatic logic [15:0] wdat(input int i);
        return 16'((i * 291) & 16'hFFFF) ^ 16'hBEEF;
    endfunction

    initial begin
        int seen;

        // Reset values
        cyc();
        cyc();
        check("rst_rdy", {31'd0, o_chip_rdy}, 32'd0);
        check("rst_vld", {31'd0, o_tx_vld}, 32'd0);
        check("rst_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_ovf", {24'd0, o_ovf_cnt}, 32'd0);
        check("rst_lvl", {27'd0, o_fifo_lvl}, 32'd0);
        i_rst = 1'b0;
        cyc();
        check("rel_rdy", {31'd0, o_chip_rdy}, 32'd1);

        // Single word, done returned 3 cycles after each byte
        put_word(7'h05, 16'h1234);
        check("t1_lvl1", {27'd0, o_fifo_lvl}, 32'd1);
        cyc();
        get_byte("t1_hdr", 8'hA5, 0);
        send_done(3);
        get_byte("t1_sel", 8'h05, 0);
        send_done(3);
        get_byte("t1_dhi", 8'h12, 0);
        send_done(3);
        get_byte("t1_dlo", 8'h34, 0);
        send_done(3);
`ifdef CHIP_RX_CHKSUM_EN
        get_byte("t1_chk", 8'h23, 0);
        send_done(3);
`endif
        check("t1_lvl0", {27'd0, o_fifo_lvl}, 32'd0);
        check("t1_ovf", {24'd0, o_ovf_cnt}, 32'd0);
        i_tx_done = 1'b1;
        cyc();
        i_tx_done = 1'b0;
        cyc();
        check("t1_idle_done", {31'd0, o_tx_vld}, 32'd0);

        // Backpressure: word 0 sits in the packer, 14 more fill the FIFO
        do_reset();
        for (int i = 0; i < 15; i++) put_word(7'(i), 16'h1000 + 16'(i));
        check("t2_lvl14", {27'd0, o_fifo_lvl}, 32'd14);
        check("t2_rdy_hi", {31'd0, o_chip_rdy}, 32'd1);
        cyc();
        check("t2_rdy_lo", {31'd0, o_chip_rdy}, 32'd0);
        check("t2_ovf", {24'd0, o_ovf_cnt}, 32'd0);

        // Overflow: two more fit, three drop
        for (int i = 15; i < 20; i++) put_word(7'(i), 16'h1000 + 16'(i));
        check("t3_lvl16", {27'd0, o_fifo_lvl}, 32'd16);
        check("t3_ovf3", {24'd0, o_ovf_cnt}, 32'd3);
        i_chip_vld = 1'b1;
        for (int i = 0; i < 300; i++) cyc();
        i_chip_vld = 1'b0;
        check("t3_ovf_sat", {24'd0, o_ovf_cnt}, 32'd255);
        check("t3_lvl_sat", {27'd0, o_fifo_lvl}, 32'd16);
        check("t3_hdr_held", {24'd0, o_tx_data}, 32'h0000_00A5);
        send_done(0);
        get_frame("t3_f0", 7'd0, 16'h1000, 1, 0, 0);
        get_frame("t3_f1", 7'd1, 16'h1001, 0, 0, 0);
        check("t3_lvl14", {27'd0, o_fifo_lvl}, 32'd14);

        // Back-to-back frames with tx_done on the tx_vld cycle
        do_reset();
        check("t4_ovf_clr", {24'd0, o_ovf_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) put_word(7'(8'h40 + i), 16'h5A00 + 16'(i));
        check("t4_lvl2", {27'd0, o_fifo_lvl}, 32'd2);
        check("t4_hdr_held", {24'd0, o_tx_data}, 32'h0000_00A5);
        send_done(0);
        get_frame("t4_f0", 7'h40, 16'h5A00, 1, 0, 0);
        get_frame("t4_f1", 7'h41, 16'h5A01, 0, 0, 0);
        get_frame("t4_f2", 7'h42, 16'h5A02, 0, 0, 0);
        check("t4_lvl0", {27'd0, o_fifo_lvl}, 32'd0);

        // Wrap-around: 40 words with random done delay
        do_reset();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int g = 0;
                    while (!o_chip_rdy && g < 500) begin
                        cyc();
                        g++;
                    end
                    put_word(wsel(i), wdat(i));
                    if ($urandom_range(0, 1) == 1) cyc();
                end
            end
            begin
                for (int f = 0; f < 40; f++) get_frame("t5", wsel(f), wdat(f), 0, -1, -1);
            end
        join
        check("t5_lvl0", {27'd0, o_fifo_lvl}, 32'd0);
        check("t5_ovf0", {24'd0, o_ovf_cnt}, 32'd0);

        // Reset mid-frame after the SEL byte
        do_reset();
        for (int i = 0; i < 5; i++) put_word(7'(8'h10 + i), 16'h7700 + 16'(i));
        check("t6_lvl4", {27'd0, o_fifo_lvl}, 32'd4);
        send_done(0);
        get_byte("t6_sel", 8'h10, 0);
        i_rst = 1'b1;
        cyc();
        check("t6_vld", {31'd0, o_tx_vld}, 32'd0);
        check("t6_lvl", {27'd0, o_fifo_lvl}, 32'd0);
        check("t6_rdy", {31'd0, o_chip_rdy}, 32'd0);
        i_rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (o_tx_vld) seen++;
        end
        check("t6_stale", seen, 0);
        check("t6_rdy_rel", {31'd0, o_chip_rdy}, 32'd1);
        check("t6_lvl_rel", {27'd0, o_fifo_lvl}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
